uart_byte_receiver: RTL and testbench

//  Serial receive end of the board UART link: recovers 8N1 bytes from the rx pin at the same
//  bit period the transmit path divides down from clk (5208 clk cycles = 9600 baud @ 50 MHz).

---
 rtl/uart_byte_receiver.sv | 135 +++++++++++++
 tb/tb_uart_byte_receiver.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_receiver.sv
// rtl/uart_byte_receiver.sv - 8N1 serial byte receiver with mid-bit sampling.
// Bit timing restarts on every start bit; bytes are delivered with a one-cycle strobe.
module uart_byte_receiver #(
    parameter int BIT_PERIOD = 5208,
    parameter int CNT_W      = 13
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(BIT_PERIOD / 2 - 1);
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(BIT_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        WAIT_HI = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_out_q, data_out_d;
    logic               data_valid_q, data_valid_d;
    logic               frame_err_q, frame_err_d;
    logic               rx_meta_q, rx_meta_d;
    logic               rx_s_q, rx_s_d;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        rx_meta_d    = rx;
        rx_s_d       = rx_meta_q;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s_q) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d     = '0;
                    bit_idx_d = 3'd0;
                    // A start bit that is high again at its midpoint was only a glitch.
                    state_d   = rx_s_q ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == LAST) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        data_out_d   = shift_q;
                        data_valid_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HI: begin
                // Holding here keeps a long break from reporting more than one error.
                cnt_d = '0;
                if (rx_s_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= 3'd0;
            shift_q      <= 8'd0;
            data_out_q   <= 8'd0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            frame_err_q  <= frame_err_d;
            rx_meta_q    <= rx_meta_d;
            rx_s_q       <= rx_s_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_byte_receiver.sv
// tb/tb_uart_byte_receiver.sv - randomized scoreboard bench for uart_byte_receiver.
module tb_uart_byte_receiver;

    localparam int BP   = 16;
    localparam int HALF = BP / 2;
    localparam int LAT  = HALF + 9 * BP + 3;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         t_fall = 0;
    int         last_dv_cyc = -1;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    logic [7:0] exp_data;

    uart_byte_receiver #(.BIT_PERIOD(BP), .CNT_W(5)) dut (
        .clk        (clk),
        .Reset      (Reset),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Strobe monitor: records every event as {is_frame_err, data_out}.
    always @(negedge clk) begin
        if (!Reset && (data_valid || frame_err)) begin
            check("strobe_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
            if (data_valid) begin
                check("busy_low_on_valid", {31'd0, busy}, 32'd0);
                last_dv_cyc = cyc;
            end
            got_q.push_back({frame_err, data_out});
        end
    end

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Reference: a good stop bit delivers the byte; a bad one reports an error
    // and leaves the last good byte in place.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        t_fall = cyc;
        hold(1'b0, BP);
        for (int i = 0; i < 8; i++) hold(b[i], BP);
        hold(stop, BP);
        if (stop) begin
            exp_q.push_back({1'b0, b});
            exp_data = b;
        end else begin
            exp_q.push_back({1'b1, exp_data});
        end
    endtask

    task automatic compare_events(input string tag);
        int n;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_event"}, {23'd0, got_q[i]}, {23'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        exp_data = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        Reset = 1'b0;

        // 1: idle line after reset
        hold(1'b1, 100);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_valid", {31'd0, data_valid}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        compare_events("idle");

        // 2: single frame with latency
        send_frame(8'hA5, 1'b1);
        hold(1'b1, 2 * BP);
        check("lat_min", {31'd0, (last_dv_cyc - t_fall) >= LAT - 1}, 32'd1);
        check("lat_max", {31'd0, (last_dv_cyc - t_fall) <= LAT + 1}, 32'd1);
        check("a5_data", {24'd0, data_out}, 32'hA5);
        compare_events("a5");

        // 3: back-to-back with no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        hold(1'b1, 2 * BP);
        compare_events("b2b");

        // 4: short glitch on the line
        hold(1'b0, 4);
        hold(1'b1, 3 * BP);
        check("glitch_busy", {31'd0, busy}, 32'd0);
        check("glitch_data", {24'd0, data_out}, 32'hFF);
        compare_events("glitch");

        // 5: bad stop bit, stuck low, then recovery
        send_frame(8'h3C, 1'b0);
        hold(1'b0, 50);
        hold(1'b1, 2 * BP);
        check("ferr_data", {24'd0, data_out}, 32'hFF);
        send_frame(8'h81, 1'b1);
        hold(1'b1, 2 * BP);
        compare_events("ferr");

        // random frames, gaps and stop-bit errors
        for (int f = 0; f < 16; f++) begin
            logic [7:0] b;
            logic       stop;
            b    = 8'($urandom);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop);
            if (!stop) begin
                hold(1'b0, $urandom_range(0, 30));
                hold(1'b1, BP + $urandom_range(0, 20));
            end else if ($urandom_range(0, 2) != 0) begin
                hold(1'b1, $urandom_range(1, 20));
            end
        end
        hold(1'b1, 2 * BP);
        check("rand_data", {24'd0, data_out}, {24'd0, exp_data});
        compare_events("rand");

        // 6: reset during bit 4 of 0x5A
        if (exp_data == 8'd0) begin
            send_frame(8'h77, 1'b1);
            hold(1'b1, 2 * BP);
        end
        compare_events("pre_rst");
        hold(1'b0, BP);
        for (int i = 0; i < 4; i++) hold(logic'(i[0] ? 1'b1 : 1'b0), BP);
        hold(1'b1, HALF);
        check("mid_busy", {31'd0, busy}, 32'd1);
        Reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_busy", {31'd0, busy}, 32'd0);
        check("mrst_data", {24'd0, data_out}, 32'd0);
        check("mrst_valid", {31'd0, data_valid}, 32'd0);
        check("mrst_ferr", {31'd0, frame_err}, 32'd0);
        Reset = 1'b0;
        exp_data = 8'd0;
        got_q.delete();
        hold(1'b1, 2 * BP);
        send_frame(8'h5A, 1'b1);
        hold(1'b1, 2 * BP);
        check("post_rst_data", {24'd0, data_out}, 32'h5A);
        compare_events("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
